// File: rtl/psr_branch_sequencer.sv
// PSR-driven micro-sequencer: evaluates SPARC-style condition codes against the
// PSR flags and steps, jumps, calls or returns the registered micro-PC.
module psr_branch_sequencer #(
    parameter int unsigned PSRBS_PSR   = 4,
    parameter int unsigned PSRBS_UADDR = 11,
    parameter int unsigned PSRBS_DEPTH = 4
) (
    input  logic                           PSRBS_CLOCK_50,
    input  logic                           PSRBS_ResetInHigh_In,
    input  logic [PSRBS_PSR-1:0]           PSRBS_Psr_InBus,
    input  logic [3:0]                     PSRBS_Cond_InBus,
    input  logic [1:0]                     PSRBS_Mode_InBus,
    input  logic [PSRBS_UADDR-1:0]         PSRBS_Target_InBus,
    input  logic                           PSRBS_Stall_In,
    output logic [PSRBS_UADDR-1:0]         PSRBS_Upc_OutBus,
    output logic                           PSRBS_Taken_Out,
    output logic [$clog2(PSRBS_DEPTH):0]   PSRBS_StackLevel_OutBus,
    output logic                           PSRBS_StackError_Out
);

    localparam int unsigned PtrW   = $clog2(PSRBS_DEPTH);
    localparam int unsigned LevelW = PtrW + 1;
    localparam logic [LevelW-1:0] LevelFull = LevelW'(PSRBS_DEPTH);
    localparam logic [LevelW-1:0] LevelOne  = LevelW'(1);
    localparam logic [PSRBS_UADDR-1:0] UaddrOne = PSRBS_UADDR'(1);

    typedef enum logic [1:0] {
        ModeNext   = 2'b00,
        ModeJump   = 2'b01,
        ModeCall   = 2'b10,
        ModeReturn = 2'b11
    } mode_e;

    logic [PSRBS_UADDR-1:0] upc_q, upc_d;
    logic                   taken_q, taken_d;
    logic [LevelW-1:0]      level_q, level_d;
    logic                   err_q, err_d;

    logic [PSRBS_UADDR-1:0] stack_mem [PSRBS_DEPTH];
    logic [PSRBS_UADDR-1:0] upc_inc;
    logic [PtrW-1:0]        wr_ptr;
    logic [PtrW-1:0]        top_ptr;
    logic                   push;
    logic                   cond_true;
    logic                   base_cond;
    logic                   flag_n, flag_z, flag_v, flag_c, flag_d;
    logic                   full, empty;
    mode_e                  mode;

    assign flag_n = PSRBS_Psr_InBus[3];
    assign flag_z = PSRBS_Psr_InBus[2];
    assign flag_v = PSRBS_Psr_InBus[1];
    assign flag_c = PSRBS_Psr_InBus[0];
    assign flag_d = flag_n ^ flag_v;
    assign mode   = mode_e'(PSRBS_Mode_InBus);

    assign upc_inc = upc_q + UaddrOne;
    // Push slot is the current level; top of stack is one below (wraps when full).
    assign wr_ptr  = level_q[PtrW-1:0];
    assign top_ptr = wr_ptr - PtrW'(1);
    assign full    = (level_q == LevelFull);
    assign empty   = (level_q == '0);

    // Condition codes 8..15 are the complements of 0..7.
    always_comb begin
        base_cond = 1'b0;
        unique case (PSRBS_Cond_InBus[2:0])
            3'd0: base_cond = 1'b0;
            3'd1: base_cond = flag_z;
            3'd2: base_cond = flag_z | flag_d;
            3'd3: base_cond = flag_d;
            3'd4: base_cond = flag_c | flag_z;
            3'd5: base_cond = flag_c;
            3'd6: base_cond = flag_n;
            3'd7: base_cond = flag_v;
            default: base_cond = 1'b0;
        endcase
        cond_true = base_cond ^ PSRBS_Cond_InBus[3];
    end

    // Next-state selection for uPC, taken, stack level and sticky error.
    always_comb begin
        upc_d   = upc_q;
        taken_d = taken_q;
        level_d = level_q;
        err_d   = err_q;
        push    = 1'b0;
        if (!PSRBS_Stall_In) begin
            upc_d   = upc_inc;
            taken_d = 1'b0;
            unique case (mode)
                ModeNext: ;
                ModeJump: begin
                    if (cond_true) begin
                        upc_d   = PSRBS_Target_InBus;
                        taken_d = 1'b1;
                    end
                end
                ModeCall: begin
                    if (cond_true) begin
                        upc_d   = PSRBS_Target_InBus;
                        taken_d = 1'b1;
                        if (full) begin
                            err_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            level_d = level_q + LevelOne;
                        end
                    end
                end
                ModeReturn: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        upc_d   = stack_mem[top_ptr];
                        taken_d = 1'b1;
                        level_d = level_q - LevelOne;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge PSRBS_CLOCK_50 or posedge PSRBS_ResetInHigh_In) begin
        if (PSRBS_ResetInHigh_In) begin
            upc_q   <= '0;
            taken_q <= 1'b0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            upc_q   <= upc_d;
            taken_q <= taken_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents need no reset since level gates reads.
    always_ff @(posedge PSRBS_CLOCK_50) begin
        if (push && !PSRBS_ResetInHigh_In) begin
            stack_mem[wr_ptr] <= upc_inc;
        end
    end

    assign PSRBS_Upc_OutBus        = upc_q;
    assign PSRBS_Taken_Out         = taken_q;
    assign PSRBS_StackLevel_OutBus = level_q;
    assign PSRBS_StackError_Out    = err_q;

endmodule

// File: tb/tb_psr_branch_sequencer.sv
// Self-checking bench: a queue-based reference model checked every cycle, plus
// directed literal expectations for the documented scenarios.
module tb_psr_branch_sequencer;

    localparam int UADDR = 11;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       psr = 4'b0000;
    logic [3:0]       cond = 4'd0;
    logic [1:0]       mode = 2'b00;
    logic [UADDR-1:0] target = '0;
    logic             stall = 1'b0;

    logic [UADDR-1:0] upc;
    logic             taken;
    logic [2:0]       level;
    logic             serr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_upc   = 0;
    bit          m_taken = 0;
    bit          m_err   = 0;
    int unsigned m_stack[$];

    psr_branch_sequencer #(
        .PSRBS_PSR   (4),
        .PSRBS_UADDR (UADDR),
        .PSRBS_DEPTH (DEPTH)
    ) dut (
        .PSRBS_CLOCK_50          (clk),
        .PSRBS_ResetInHigh_In    (rst),
        .PSRBS_Psr_InBus         (psr),
        .PSRBS_Cond_InBus        (cond),
        .PSRBS_Mode_InBus        (mode),
        .PSRBS_Target_InBus      (target),
        .PSRBS_Stall_In          (stall),
        .PSRBS_Upc_OutBus        (upc),
        .PSRBS_Taken_Out         (taken),
        .PSRBS_StackLevel_OutBus (level),
        .PSRBS_StackError_Out    (serr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition table written as named integer comparisons.
    function automatic bit eval_cond(input logic [3:0] c, input logic [3:0] p);
        bit n, z, v, cy, signed_lt, unsigned_le;
        n = p[3]; z = p[2]; v = p[1]; cy = p[0];
        signed_lt   = (n != v);
        unsigned_le = cy || z;
        case (c)
            4'd0:  return 0;
            4'd1:  return z;
            4'd2:  return z || signed_lt;
            4'd3:  return signed_lt;
            4'd4:  return unsigned_le;
            4'd5:  return cy;
            4'd6:  return n;
            4'd7:  return v;
            4'd8:  return 1;
            4'd9:  return !z;
            4'd10: return !(z || signed_lt);
            4'd11: return !signed_lt;
            4'd12: return !unsigned_le;
            4'd13: return !cy;
            4'd14: return !n;
            default: return !v;
        endcase
    endfunction

    // Reference model update
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_upc = 0; m_taken = 0; m_err = 0;
            m_stack.delete();
        end else if (!stall) begin
            int unsigned nxt;
            bit c;
            nxt = (m_upc + 1) % (1 << UADDR);
            c = eval_cond(cond, psr);
            m_taken = 0;
            case (mode)
                2'b00: m_upc = nxt;
                2'b01: begin
                    if (c) begin m_upc = target; m_taken = 1; end
                    else m_upc = nxt;
                end
                2'b10: begin
                    if (c) begin
                        if (m_stack.size() < DEPTH) m_stack.push_back(nxt);
                        else m_err = 1;
                        m_upc = target; m_taken = 1;
                    end else m_upc = nxt;
                end
                default: begin
                    if (m_stack.size() > 0) begin
                        m_upc = m_stack.pop_back(); m_taken = 1;
                    end else begin
                        m_upc = nxt; m_err = 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("model_upc",   upc,   m_upc);
            check("model_taken", taken, m_taken);
            check("model_level", level, m_stack.size());
            check("model_err",   serr,  m_err);
        end
    end

    task automatic apply(input logic [1:0] md, input logic [3:0] cd, input logic [3:0] ps,
                         input logic [UADDR-1:0] tg, input logic st);
        mode = md; cond = cd; psr = ps; target = tg; stall = st;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string name, input int unsigned e_upc, input bit e_taken,
                                input int unsigned e_level, input bit e_err);
        check({name, "_upc"},   upc,   e_upc);
        check({name, "_taken"}, taken, e_taken);
        check({name, "_level"}, level, e_level);
        check({name, "_err"},   serr,  e_err);
    endtask

    initial begin
        #7;
        expect_state("reset", 0, 0, 0, 0);
        #15 rst = 1'b0;
        @(posedge clk); #2;  // idle NEXT edge is avoided: inputs default to NEXT
        // Re-sync: restart from reset so the NEXT sequence starts at 0.
        rst = 1'b1; #1; rst = 1'b0;
        expect_state("reset2", 0, 0, 0, 0);

        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("next1", 1, 0, 0, 0);
        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("next2", 2, 0, 0, 0);
        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("next3", 3, 0, 0, 0);
        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0);
        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0); check("upc5", upc, 5);

        apply(2'b01, 4'd1, 4'b0100, 11'h100, 1'b0); expect_state("jump_e_t", 11'h100, 1, 0, 0);
        apply(2'b01, 4'd8, 4'b0000, 11'h005, 1'b0); check("back_to5", upc, 5);
        apply(2'b01, 4'd1, 4'b0000, 11'h100, 1'b0); expect_state("jump_e_nt", 6, 0, 0, 0);

        apply(2'b01, 4'd3,  4'b1000, 11'h050, 1'b0); expect_state("jump_l", 11'h050, 1, 0, 0);
        apply(2'b01, 4'd11, 4'b1000, 11'h060, 1'b0); expect_state("jump_ge", 11'h051, 0, 0, 0);
        apply(2'b01, 4'd12, 4'b0001, 11'h070, 1'b0); expect_state("jump_gu", 11'h052, 0, 0, 0);
        apply(2'b01, 4'd13, 4'b0001, 11'h070, 1'b0); expect_state("jump_cc", 11'h053, 0, 0, 0);
        apply(2'b01, 4'd2,  4'b0010, 11'h0A0, 1'b0); expect_state("jump_le", 11'h0A0, 1, 0, 0);
        apply(2'b01, 4'd10, 4'b1010, 11'h0B0, 1'b0); expect_state("jump_g", 11'h0B0, 1, 0, 0);
        apply(2'b01, 4'd4,  4'b0000, 11'h0C0, 1'b0); expect_state("jump_leu", 11'h0B1, 0, 0, 0);

        apply(2'b01, 4'd8, 4'b0000, 11'h010, 1'b0); check("upc10", upc, 11'h010);
        apply(2'b10, 4'd8, 4'b0000, 11'h200, 1'b0); expect_state("call", 11'h200, 1, 1, 0);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("ret", 11'h011, 1, 0, 0);
        apply(2'b10, 4'd0, 4'b1111, 11'h3FF, 1'b0); expect_state("call_nt", 11'h012, 0, 0, 0);

        apply(2'b10, 4'd8, 4'b0000, 11'h300, 1'b0); expect_state("nest1", 11'h300, 1, 1, 0);
        apply(2'b10, 4'd8, 4'b0000, 11'h310, 1'b0); expect_state("nest2", 11'h310, 1, 2, 0);
        apply(2'b10, 4'd8, 4'b0000, 11'h320, 1'b0); expect_state("nest3", 11'h320, 1, 3, 0);
        apply(2'b10, 4'd8, 4'b0000, 11'h330, 1'b0); expect_state("nest4", 11'h330, 1, 4, 0);
        apply(2'b10, 4'd8, 4'b0000, 11'h340, 1'b0); expect_state("nest5", 11'h340, 1, 4, 1);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("pop1", 11'h321, 1, 3, 1);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("pop2", 11'h311, 1, 2, 1);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("pop3", 11'h301, 1, 1, 1);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("pop4", 11'h013, 1, 0, 1);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("pop5", 11'h014, 0, 0, 1);

        apply(2'b01, 4'd8, 4'b0000, 11'h7FF, 1'b0); check("upc7ff", upc, 11'h7FF);
        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("wrap", 0, 0, 0, 1);
        apply(2'b10, 4'd8, 4'b0000, 11'h123, 1'b1); expect_state("stall", 0, 0, 0, 1);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b1); expect_state("stall_ret", 0, 0, 0, 1);

        apply(2'b10, 4'd8, 4'b0000, 11'h123, 1'b0); expect_state("call2", 11'h123, 1, 1, 1);
        mode = 2'b10; cond = 4'd8; target = 11'h456; stall = 1'b0;
        #1 rst = 1'b1;
        #1 expect_state("async_rst", 0, 0, 0, 0);
        @(posedge clk); #1 expect_state("rst_hold", 0, 0, 0, 0);
        #2 rst = 1'b0;
        apply(2'b00, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("post_rst", 1, 0, 0, 0);
        apply(2'b11, 4'd0, 4'b0000, 11'h000, 1'b0); expect_state("ret_empty", 2, 0, 0, 1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
